hqm_mem_rf_2p_init: RTL and testbench

//  Parametrised single-clock two-port (1W/1R) register file with behavioural storage.

---
 rtl/hqm_mem_rf_2p_init.sv | 162 ++++++++++++++++
 tb/tb_hqm_mem_rf_2p_init.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_mem_rf_2p_init.sv
// 1W/1R register file with hardware clear, stored parity and error injection.
// Illegal or dropped accesses are flagged with single-cycle pulses.
module hqm_mem_rf_2p_init #(
    parameter int                DEPTH    = 256,
    parameter int                DWIDTH   = 10,
    parameter int                AWIDTH   = $clog2(DEPTH),
    parameter int                RD_LAT   = 1,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              par_inj,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic              rvalid,
    output logic [DWIDTH-1:0] rdata,
    output logic              rpar_err,
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_done,
    output logic              err_drop,
    output logic              err_oor
);

    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST      = AWIDTH'(DEPTH - 1);
    localparam logic [DWIDTH:0]   INIT_WORD = {^INIT_VAL, INIT_VAL};

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("hqm_mem_rf_2p_init: RD_LAT must be 1 or 2");
    end

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t            state_q;
    logic [AWIDTH-1:0] init_cnt_q;
    logic              init_busy_q;
    logic              init_done_q;

    logic [DWIDTH:0]   mem_q [DEPTH];

    logic              waddr_oor;
    logic              raddr_oor;
    logic              we_ok;
    logic              re_ok;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_wa;
    logic [DWIDTH:0]   mem_wd;
    logic [DWIDTH:0]   rd_word;
    logic              out_v;
    logic [DWIDTH:0]   out_w;

    logic              s1_v_d, s1_v_q;
    logic [DWIDTH:0]   s1_w_d, s1_w_q;
    logic              rvalid_d, rvalid_q;
    logic [DWIDTH-1:0] rdata_d, rdata_q;
    logic              rpar_err_d, rpar_err_q;
    logic              err_drop_d, err_drop_q;
    logic              err_oor_d, err_oor_q;

    // Clear sequencer: one entry per cycle, restartable from READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST) begin
                        state_q     <= S_READY;
                        init_cnt_q  <= '0;
                        init_busy_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
                S_READY: begin
                    if (init_req) begin
                        state_q     <= S_INIT;
                        init_cnt_q  <= '0;
                        init_busy_q <= 1'b1;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    always_comb begin
        waddr_oor = ({1'b0, waddr} >= DEPTH_W);
        raddr_oor = ({1'b0, raddr} >= DEPTH_W);
        we_ok     = we & ~init_busy_q & ~waddr_oor;
        re_ok     = re & ~init_busy_q;
        mem_we    = init_busy_q | we_ok;
        mem_wa    = init_busy_q ? init_cnt_q : waddr;
        mem_wd    = init_busy_q ? INIT_WORD : {^wdata ^ par_inj, wdata};
        rd_word   = raddr_oor ? '0 : mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Array is sampled before this edge's write, giving read-before-write.
    always_comb begin
        s1_v_d = re_ok;
        s1_w_d = s1_w_q;
        if (re_ok) begin
            s1_w_d = rd_word;
        end
        out_v      = (RD_LAT == 1) ? re_ok : s1_v_q;
        out_w      = (RD_LAT == 1) ? rd_word : s1_w_q;
        rvalid_d   = out_v;
        rdata_d    = rdata_q;
        rpar_err_d = rpar_err_q;
        if (out_v) begin
            rdata_d    = out_w[DWIDTH-1:0];
            rpar_err_d = ^out_w;
        end
        err_drop_d = init_busy_q & (we | re);
        err_oor_d  = ~init_busy_q & ((we & waddr_oor) | (re & raddr_oor));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_w_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rpar_err_q <= 1'b0;
            err_drop_q <= 1'b0;
            err_oor_q  <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_w_q     <= s1_w_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rpar_err_q <= rpar_err_d;
            err_drop_q <= err_drop_d;
            err_oor_q  <= err_oor_d;
        end
    end

    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign rpar_err  = rpar_err_q;
    assign init_busy = init_busy_q;
    assign init_done = init_done_q;
    assign err_drop  = err_drop_q;
    assign err_oor   = err_oor_q;

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({we, re, init_req}));

endmodule

// File: tb/tb_hqm_mem_rf_2p_init.sv
// Bench for hqm_mem_rf_2p_init: array/queue reference model with a scoreboard
// monitor checking read returns, latency and error pulses.
module tb_hqm_mem_rf_2p_init;

    localparam int DEPTH  = 200;
    localparam int DWIDTH = 10;
    localparam int AWIDTH = 8;
    localparam int RD_LAT = 2;
    localparam logic [DWIDTH-1:0] INIT_VAL = 10'h0C3;

    typedef struct {
        logic [DWIDTH-1:0] d;
        logic              pe;
        int                c;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;
    logic              par_inj;
    logic              re;
    logic [AWIDTH-1:0] raddr;
    logic              rvalid;
    logic [DWIDTH-1:0] rdata;
    logic              rpar_err;
    logic              init_req;
    logic              init_busy;
    logic              init_done;
    logic              err_drop;
    logic              err_oor;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_left;
    logic done_exp;
    logic exp_drop;
    logic exp_oor;
    exp_t sb[$];

    logic [DWIDTH-1:0] m_data [DEPTH];
    logic              m_pe   [DEPTH];

    hqm_mem_rf_2p_init #(
        .DEPTH(DEPTH), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .we(we), .waddr(waddr), .wdata(wdata), .par_inj(par_inj),
        .re(re), .raddr(raddr),
        .rvalid(rvalid), .rdata(rdata), .rpar_err(rpar_err),
        .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
        .err_drop(err_drop), .err_oor(err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = INIT_VAL;
            m_pe[i]   = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("err_drop", err_drop, exp_drop);
        chk("err_oor", err_oor, exp_oor);
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected rvalid: rdata=%0h", rdata);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.d);
                chk("rpar_err", rpar_err, e.pe);
                chk("rd_latency", cyc - e.c, RD_LAT);
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own view of the clear.
    task automatic step(input bit w, input int wa, input logic [DWIDTH-1:0] wd,
                        input bit pi, input bit r, input int ra, input bit ir);
        bit   rdy;
        logic e_drop;
        logic e_oor;
        exp_t e;
        we       = w;
        waddr    = AWIDTH'(wa);
        wdata    = wd;
        par_inj  = pi;
        re       = r;
        raddr    = AWIDTH'(ra);
        init_req = ir;
        rdy      = (busy_left == 0);
        e_drop   = !rdy && (w || r);
        e_oor    = rdy && ((w && wa >= DEPTH) || (r && ra >= DEPTH));
        if (rdy && r) begin
            e.d = (ra >= DEPTH) ? '0 : m_data[ra];
            e.pe = (ra >= DEPTH) ? 1'b0 : m_pe[ra];
            e.c = cyc;
            sb.push_back(e);
        end
        if (rdy && w && wa < DEPTH) begin
            m_data[wa] = wd;
            m_pe[wa]   = pi;
        end
        @(posedge clk);
        exp_drop = e_drop;
        exp_oor  = e_oor;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) done_exp = 1'b1;
        end else if (ir) begin
            busy_left = DEPTH;
            model_clear();
        end
        #1;
        chk("init_busy", init_busy, busy_left > 0);
        chk("init_done", init_done, done_exp);
        we = 0; re = 0; init_req = 0; par_inj = 0;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_drop  = 1'b0;
        exp_oor   = 1'b0;
        done_exp  = 1'b0;
        busy_left = DEPTH;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst init_busy", init_busy, 1);
        chk("rst init_done", init_done, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst rdata", rdata, 0);
        chk("rst rpar_err", rpar_err, 0);
        chk("rst err_drop", err_drop, 0);
        chk("rst err_oor", err_oor, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (busy_left > 0 && n < 2 * DEPTH) begin
            idle();
            n++;
        end
        chk("clear finished", init_busy, 0);
    endtask

    initial begin
        rst_n = 0; we = 0; waddr = 0; wdata = 0; par_inj = 0;
        re = 0; raddr = 0; init_req = 0;
        exp_drop = 0; exp_oor = 0; done_exp = 0; busy_left = DEPTH;

        do_reset();
        wait_ready();
        for (int a = 0; a < DEPTH; a++) step(0, 0, '0, 0, 1, a, 0);
        repeat (3) idle();

        step(1, 16, 10'h2A5, 0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 16, 0);
        step(1, 5, 10'h001, 0, 0, 0, 0);
        step(1, 5, 10'h3FF, 0, 1, 5, 0);
        step(0, 0, '0, 0, 1, 5, 0);
        step(1, 7, 10'h155, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 7, 0);
        step(1, 7, 10'h155, 0, 1, 7, 0);
        step(0, 0, '0, 0, 1, 7, 0);
        step(1, 199, 10'h0AA, 0, 1, 199, 0);
        step(1, 210, 10'h123, 0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 210, 0);
        step(1, 255, 10'h321, 1, 1, 255, 0);
        step(0, 0, '0, 0, 1, 199, 0);
        repeat (3) idle();

        step(0, 0, '0, 0, 1, 16, 1);
        step(0, 0, '0, 0, 1, 16, 0);
        step(1, 3, 10'h111, 0, 1, 3, 1);
        wait_ready();
        step(0, 0, '0, 0, 1, 16, 0);
        step(0, 0, '0, 0, 1, 3, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 255),
                 DWIDTH'($urandom), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(0, DEPTH - 1),
                 ($urandom_range(0, 149) == 0));
        end
        wait_ready();

        step(0, 0, '0, 0, 1, 1, 0);
        step(0, 0, '0, 0, 1, 2, 0);
        step(0, 0, '0, 0, 1, 3, 0);
        do_reset();
        wait_ready();

        step(0, 0, '0, 0, 0, 0, 1);
        repeat (100) idle();
        do_reset();
        wait_ready();
        for (int a = 0; a < DEPTH; a += 37) step(0, 0, '0, 0, 1, a, 0);

        repeat (4) idle();
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
